snes_pad_responder: RTL
=======================

Name: snes_pad_responder

Overview:
- Device-side end of the SNES controller serial link: emulates a SNES pad so an external SNES/host can poll button state from the FPGA.
- Samples the host-driven latch and clock lines and shifts a 16-bit button word out on the data line, LSB first.
- Sits beside the host-side `snes_controller` in the top level, in the `cpu_clock` domain (~4 MHz), with its pins on spare GPIO.

Parameters:
- NUM_BITS, 16, bits shifted per frame.
- SYNC_STAGES, 2, flip-flop stages on each of snes_latch and snes_clock (minimum 2).

Ports:
- clock  in  1  system clock (cpu_clock).
- rst  in  1  asynchronous, active-low reset.
- buttons  in  NUM_BITS  button word, active-low (0 = pressed). Bit 0 is shifted first, in SNES order B,Y,Sel,Start,Up,Down,Left,Right,A,X,L,R; bits 15:12 carry the pad ID.
- snes_latch  in  1  host latch, asynchronous to clock, active-high.
- snes_clock  in  1  host shift clock, asynchronous, idles high.
- snes_data  out  1  serial button data to host.
- frame_done  out  1  one-cycle pulse when the NUM_BITS-th shift completes.
- busy  out  1  high in LATCHED or SHIFTING.
- poll_count  out  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register all ones, bit counter 0.
  - snes_data=1, frame_done=0, busy=0, poll_count=0.
  - All synchronizer flops reset to the idle line levels: latch=0, clock=1.
- Synchronization and edge detection:
  - Both inputs pass through SYNC_STAGES flops.
  - One further flop on each synchronized signal gives edge detection: latch_rise, latch_fall, clk_rise.
  - Latency from a pin edge to the resulting snes_data change is SYNC_STAGES+1 clocks, i.e. 3 at the default.
- snes_data is always shift_reg[0].
- Clock ratio: clock must be at least 8x the snes_clock frequency. Standard 6 us snes_clock periods against ~4 MHz gives more than 20x.
- State machine (IDLE, LATCHED, SHIFTING, DONE):
  - IDLE: on latch_rise -> LATCHED. clk_rise is ignored.
  - LATCHED: shift_reg<=buttons every cycle while latch is high, so the word is live. Bit counter reset to 0. On latch_fall -> SHIFTING; the shift register keeps the value loaded on that cycle.
  - SHIFTING:
    - On clk_rise: shift_reg <= {1'b0, shift_reg[NUM_BITS-1:1]} and the counter increments.
    - When the counter reaches NUM_BITS: frame_done pulses for one cycle, poll_count increments, -> DONE.
  - DONE: snes_data=0, since zeros have filled the register. Extra clk_rise keeps it 0. On latch_rise -> LATCHED.
- Priorities:
  - latch_rise in any state forces LATCHED and the reload. A frame aborted this way produces no frame_done and no poll_count increment.
  - latch_fall and clk_rise in the same cycle: latch_fall wins and that clock edge is ignored.
  - clk_rise while latch is high is ignored.
- busy is combinational from state.
- frame_done is registered.

Decomposition:
- Shared package `snes_pkg`:
  - state encoding localparams.
  - Button bit-index constants: BTN_B=0 ... BTN_R=11.
  - SNES_FRAME_BITS=16.
- The host-side `snes_controller` reuses this package.
- One natural sub-module, `sync_edge_detect`: parameterised synchronizer plus rise/fall pulse outputs, instantiated twice (latch and clock).

Test Plan:
1. Reset then idle: hold rst=0, release; no pin activity -> snes_data=1, busy=0, poll_count=0.
2. Full frame: buttons=16'hFFFE (B pressed); 12 us latch pulse, then 16 clock pulses at 6 us -> sampled bits are 0 followed by fifteen 1s; frame_done pulses once; poll_count=1; snes_data=0 afterwards.
3. Live latch: buttons changes 16'hFFFF->16'hFF7F during the latch-high window -> the first bits reflect 16'hFF7F; bit 7 (Right) reads 0.
4. Abort: latch after 5 shifts -> shift register reloads; no frame_done; poll_count unchanged; the following full frame completes normally with poll_count+1.
5. Overclock and wrap: 20 clock pulses per frame -> bits 16..19 read 0. Run 256 frames -> poll_count wraps to 0.
6. Async reset mid-SHIFTING (after 8 shifts) -> all outputs return to reset values immediately; the next latch/16-clock frame is correct.

Source files
------------

// File: rtl/snes_pkg.sv
// rtl/snes_pkg.sv - shared SNES pad link constants and state encoding
// Purpose: common definitions for the SNES host-side controller and the
//          device-side pad responder (frame length, button bit indices,
//          responder state encoding).
// Ports:   none (package).
`timescale 1ns/1ps
package snes_pkg;

  localparam int SNES_FRAME_BITS = 16;

  // Button bit positions within the shifted word; bit 0 goes out first.
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;
  localparam int PAD_ID_LSB = 12;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_LATCHED_ENC  = 2'd1;
  localparam logic [1:0] ST_SHIFTING_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_LATCHED  = ST_LATCHED_ENC,
    ST_SHIFTING = ST_SHIFTING_ENC,
    ST_DONE     = ST_DONE_ENC
  } snes_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rise/fall pulses
// Purpose: brings an asynchronous pin into the clock domain and produces
//          one-cycle pulses on its synchronized rising and falling edges.
// Ports:   clock    in  system clock
//          rst      in  asynchronous active-low reset
//          i_async  in  asynchronous input pin
//          o_level  out synchronized level
//          o_rise   out one-cycle pulse on synchronized 0->1
//          o_fall   out one-cycle pulse on synchronized 1->0
`timescale 1ns/1ps
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // All flops reset to the line's idle level so no edge is seen on release.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/snes_pad_responder.sv
// rtl/snes_pad_responder.sv - device-side SNES pad emulation
// Purpose: answers SNES latch/clock polling by shifting a button word out
//          on snes_data, LSB first.
// Ports:   clock       in  system clock (cpu_clock)
//          rst         in  asynchronous active-low reset
//          buttons     in  NUM_BITS active-low button word (bits 15:12 pad ID)
//          snes_latch  in  host latch, asynchronous, active-high
//          snes_clock  in  host shift clock, asynchronous, idles high
//          snes_data   out serial data to host
//          frame_done  out one-cycle pulse after the NUM_BITS-th shift
//          busy        out high while LATCHED or SHIFTING
//          poll_count  out completed frame count, wraps at 255
`timescale 1ns/1ps
module snes_pad_responder
  import snes_pkg::*;
#(
  parameter int NUM_BITS    = SNES_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] buttons,
  input  logic                snes_latch,
  input  logic                snes_clock,
  output logic                snes_data,
  output logic                frame_done,
  output logic                busy,
  output logic [7:0]          poll_count
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  logic w_latch_level, w_latch_rise, w_latch_fall;
  logic w_clk_level, w_clk_rise, w_clk_fall;
  logic w_unused_clk;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
    .clock   (clock),
    .rst     (rst),
    .i_async (snes_latch),
    .o_level (w_latch_level),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clock_sync (
    .clock   (clock),
    .rst     (rst),
    .i_async (snes_clock),
    .o_level (w_clk_level),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  assign w_unused_clk = w_clk_level | w_clk_fall;

  snes_state_e         r_state, w_state_nx;
  logic [NUM_BITS-1:0] r_shift, w_shift_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx, w_cnt_inc;
  logic                r_frame_done, w_frame_done_nx;
  logic [7:0]          r_poll_count, w_poll_nx;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '1;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_poll_count <= 8'd0;
    end else begin
      r_state      <= w_state_nx;
      r_shift      <= w_shift_nx;
      r_cnt        <= w_cnt_nx;
      r_frame_done <= w_frame_done_nx;
      r_poll_count <= w_poll_nx;
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nx      = r_state;
    w_shift_nx      = r_shift;
    w_cnt_nx        = r_cnt;
    w_frame_done_nx = 1'b0;
    w_poll_nx       = r_poll_count;
    if (w_latch_rise) begin
      // A new latch always restarts the frame, aborting any frame in progress.
      w_state_nx = ST_LATCHED;
      w_shift_nx = buttons;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_LATCHED: begin
          // Keep the word live for the whole latch window; the value loaded
          // on the falling-edge cycle is the one shifted out.
          w_shift_nx = buttons;
          w_cnt_nx   = '0;
          if (w_latch_fall) begin
            w_state_nx = ST_SHIFTING;
          end
        end
        ST_SHIFTING: begin
          if (w_clk_rise && !w_latch_level) begin
            w_shift_nx = {1'b0, r_shift[NUM_BITS-1:1]};
            w_cnt_nx   = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(NUM_BITS)) begin
              w_frame_done_nx = 1'b1;
              w_poll_nx       = r_poll_count + 8'd1;
              w_state_nx      = ST_DONE;
            end
          end
        end
        ST_DONE: begin
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  assign snes_data  = r_shift[0];
  assign frame_done = r_frame_done;
  assign busy       = (r_state == ST_LATCHED) || (r_state == ST_SHIFTING);
  assign poll_count = r_poll_count;

endmodule
